serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//  Serial frame transmitter: accepts a parallel payload word on a valid/ready handshake.
//  Emits one bit per clock on `out`: SYNC_LEN-bit sync pattern, then DATA_W payload bits MSB first,
//  then GAP idle zeros.
//  Generates the bit streams consumed by the team's serial sequence-detector FSMs.
//  Sits between a parallel producer and a single-wire serial link.
// PARAMETERS
//  DATA_W    8       payload width in bits, >=1
//  SYNC_LEN  3       sync pattern length in bits, >=1
//  SYNC      3'b110  sync pattern, SYNC_LEN bits wide, sent MSB first
//  GAP       2       idle zero bits after payload, >=1 (guarantees frame separation)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  load_valid  in   1       producer offers load_data
//  load_data   in   DATA_W  payload word
//  load_ready  out  1       block can accept a word (high only in IDLE)
//  out         out  1       serial bit, registered
//  out_valid   out  1       high while SYNC or DATA bits are on `out`; low in GAP/IDLE
//  busy        out  1       high in any state other than IDLE
//  frame_done  out  1       one-cycle pulse during the final GAP bit
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE; out=0; out_valid=0; busy=0; frame_done=0; load_ready=1 after release.
//    - Shift register and counter are cleared.
//    - Mid-frame reset aborts the frame immediately; the payload is discarded and nothing is resumed.
//  - FSM states: IDLE -> SYNC -> DATA -> GAP -> IDLE. Encoding is one-hot; the unused-state default goes to IDLE.
//  - IDLE:
//    - out=0, load_ready=1.
//    - Handshake fires on the edge where load_valid&&load_ready. At that edge load_data is captured
//      and the counter is loaded with SYNC_LEN-1.
//    - The FSM goes to SYNC.
//  - Latency: the first sync bit appears on `out` in the cycle after the accepting edge.
//  - SYNC:
//    - out = SYNC[SYNC_LEN-1-i] for i = 0..SYNC_LEN-1.
//    - When the counter reaches 0: go to DATA, counter = DATA_W-1.
//  - DATA:
//    - out = shift-register MSB; shift left by one per cycle.
//    - When the counter reaches 0: go to GAP, counter = GAP-1.
//  - GAP:
//    - out=0, out_valid=0.
//    - frame_done=1 when the counter is 0; then go to IDLE.
//  - Frame occupancy is SYNC_LEN+DATA_W+GAP cycles.
//    Minimum load-to-load period is SYNC_LEN+DATA_W+GAP+1 (one IDLE cycle between frames).
//  - Handshake rules:
//    - load_valid while busy is ignored; the producer must hold load_valid and load_data until accepted.
//    - load_ready does not depend combinationally on load_valid.
//    - A change in load_data after acceptance has no effect on the frame in flight.
//  - Counter width: $clog2(max(SYNC_LEN,DATA_W,GAP))+1. Counters only decrement; no wrap past 0 is reachable.
//  - Elaboration: SYNC_LEN>=1, DATA_W>=1, GAP>=1, else $error.
// STRUCTURE
//  - Shared package seq_tx_pkg: state localparams (IDLE/SYNC/DATA/GAP one-hot) and default SYNC pattern.
//  - Sub-module piso_shift: DATA_W-bit parallel-in/serial-out shift register with load, shift and msb ports.
//    It is instantiated once.
//  - The top level holds the FSM, down-counter, output register and frame_done logic.
// TESTING
//  All scenarios use defaults (DATA_W=8, SYNC=3'b110, GAP=2).
//  1. Reset, then load 8'hA5:
//     -> out = 1,1,0,1,0,1,0,0,1,0,1,0,0 over 13 cycles from cycle+1.
//     -> out_valid high for the first 11 bits; frame_done on cycle 13; load_ready back high on cycle 14.
//  2. Hold load_valid high continuously with 8'hFF then 8'h00:
//     -> second frame starts exactly 14 cycles after the first; zero idle bits between frames, apart from GAP+1.
//  3. Pulse load_valid with 8'h3C while busy (mid-DATA):
//     -> ignored; out and busy are unchanged; no extra frame.
//  4. Assert rst_n=0 asynchronously between clock edges during DATA bit 4:
//     -> out, busy and out_valid go to 0 without waiting for a clock edge.
//     -> after release, IDLE with load_ready=1 and out stays 0.
//  5. Re-parameterise DATA_W=1, SYNC_LEN=1, SYNC=1'b1, GAP=1 and load 1'b0:
//     -> out = 1,0,0; frame_done on the 3rd bit; verifies counter boundaries.
//  6. Change load_data on the cycle after acceptance:
//     -> transmitted payload equals the value captured at the accepting edge.

Source files
------------

// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial sequence transmitters: one-hot FSM states,
// the default sync pattern and a small elaboration helper.
package seq_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_SYNC = 4'b0010,
    ST_DATA = 4'b0100,
    ST_GAP  = 4'b1000
  } state_e;

  localparam logic [2:0] DEFAULT_SYNC = 3'b110;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in/serial-out shift register; msb is the bit currently at the head.
module piso_shift #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sync pattern, payload MSB first, then idle gap zeros,
// one bit per clock, with a valid/ready load port.
module serial_frame_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned         DATA_W   = 8,
  parameter int unsigned         SYNC_LEN = 3,
  parameter logic [SYNC_LEN-1:0] SYNC     = SYNC_LEN'(DEFAULT_SYNC),
  parameter int unsigned         GAP      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CNT_W = $clog2(max3(SYNC_LEN, DATA_W, GAP)) + 1;

  if (SYNC_LEN == 0 || DATA_W == 0 || GAP == 0) begin : g_param_check
    $error("serial_frame_tx: SYNC_LEN, DATA_W and GAP must all be >= 1");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                load_ready_q, load_ready_d;
  logic                sr_load, sr_shift, sr_msb;
  logic [SYNC_LEN-1:0] sync_sh;

  piso_shift #(.W(DATA_W)) u_piso (
    .clk  (clk),
    .rst_n(rst_n),
    .load (sr_load),
    .shift(sr_shift),
    .din  (load_data),
    .msb  (sr_msb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid && load_ready_q) begin
          state_d = ST_SYNC;
          cnt_d   = CNT_W'(SYNC_LEN - 1);
          sr_load = 1'b1;
        end
      end
      ST_SYNC: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = CNT_W'(DATA_W - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(GAP - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so each bit lands on `out`
  // in the same cycle the FSM occupies its slot (first sync bit right after accept).
  always_comb begin
    sync_sh      = SYNC >> cnt_d;
    sr_shift     = (state_d == ST_DATA);
    out_d        = 1'b0;
    if (state_d == ST_SYNC) begin
      out_d = sync_sh[0];
    end else if (state_d == ST_DATA) begin
      out_d = sr_msb;
    end
    out_valid_d  = (state_d == ST_SYNC) || (state_d == ST_DATA);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_GAP) && (cnt_d == '0);
    load_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      out_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign load_ready = load_ready_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: queue-based frame model plus directed literal checks.
`timescale 1ns/1ps
module tb_serial_frame_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned SL = 3;
  localparam int unsigned GP = 2;
  localparam logic [SL-1:0] SP = 3'b110;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lv = 1'b0;
  logic [DW-1:0] ld = '0;
  logic          load_ready, out, out_valid, busy, frame_done;

  logic          lv2 = 1'b0;
  logic [0:0]    ld2 = '0;
  logic          load_ready2, out2, out_valid2, busy2, frame_done2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(DW), .SYNC_LEN(SL), .SYNC(SP), .GAP(GP)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(lv), .load_data(ld),
    .load_ready(load_ready), .out(out), .out_valid(out_valid),
    .busy(busy), .frame_done(frame_done)
  );

  serial_frame_tx #(.DATA_W(1), .SYNC_LEN(1), .SYNC(1'b1), .GAP(1)) dut_min (
    .clk(clk), .rst_n(rst_n), .load_valid(lv2), .load_data(ld2),
    .load_ready(load_ready2), .out(out2), .out_valid(out_valid2),
    .busy(busy2), .frame_done(frame_done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one entry per line cycle of an accepted frame.
  typedef struct packed {logic o; logic v; logic d;} beat_t;
  beat_t exp_q[$];

  function automatic void push_frame(input logic [DW-1:0] p);
    for (int i = SL - 1; i >= 0; i--) exp_q.push_back('{SP[i], 1'b1, 1'b0});
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back('{p[i], 1'b1, 1'b0});
    for (int i = GP - 1; i >= 0; i--) exp_q.push_back('{1'b0, 1'b0, (i == 0)});
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q.delete();
    else if (exp_q.size() != 0) exp_q.delete(0);
    else if (lv) push_frame(ld);
  end

  always @(negedge clk) begin : cmp
    beat_t e;
    logic  eb;
    if (rst_n) begin
      eb = (exp_q.size() != 0);
      e  = eb ? exp_q[0] : '0;
      check("out", out, e.o);
      check("out_valid", out_valid, e.v);
      check("frame_done", frame_done, e.d);
      check("busy", busy, eb);
      check("load_ready", load_ready, !eb);
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (!load_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", load_ready, 1);
  endtask

  // Returns at the first negedge of the accepted frame, with load_data already scrambled.
  task automatic send(input logic [DW-1:0] d);
    int k = 0;
    lv = 1'b1;
    ld = d;
    while (!load_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("accept_timeout", load_ready, 1);
    @(negedge clk);
    lv = 1'b0;
    ld = DW'($urandom);
  endtask

  logic [12:0] t1_o, t1_v, t1_d;
  logic [7:0]  t6_bits;
  logic [2:0]  m_o, m_v, m_d;
  int          first, second, fd_count;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    t1_o = '0; t1_v = '0; t1_d = '0; t6_bits = '0;
    m_o = '0; m_v = '0; m_d = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", load_ready, 1);
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);

    // Single frame 8'hA5, literal expectations
    lv = 1'b1; ld = 8'hA5;
    @(posedge clk);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      lv = 1'b0;
      t1_o = {t1_o[11:0], out};
      t1_v = {t1_v[11:0], out_valid};
      t1_d = {t1_d[11:0], frame_done};
    end
    check("t1_out", t1_o, 13'b1101010010100);
    check("t1_valid", t1_v, 13'b1111111111100);
    check("t1_done", t1_d, 13'b0000000000001);
    @(negedge clk);
    check("t1_ready_c14", load_ready, 1);

    // Back-to-back with load_valid held high
    lv = 1'b1; ld = 8'hFF; first = -1; second = -1;
    for (int c = 0; c < 40; c++) begin
      if (load_ready) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end else if (first >= 0) begin
        ld = 8'h00;
      end
      @(negedge clk);
      if (second >= 0) break;
    end
    lv = 1'b0;
    check("t2_period", second - first, 14);
    wait_idle();

    // Load pulse while busy is ignored
    send(8'h5A);
    repeat (5) @(negedge clk);
    lv = 1'b1; ld = 8'h3C;
    @(negedge clk);
    lv = 1'b0;
    fd_count = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_done) fd_count++;
    end
    check("t3_done_count", fd_count, 1);
    check("t3_idle", busy, 0);

    // Asynchronous reset during the data phase
    send(8'hFF);
    repeat (6) @(negedge clk);
    check("t4_pre_out", out, 1);
    check("t4_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_out", out, 0);
    check("t4_async_busy", busy, 0);
    check("t4_async_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("t4_post_ready", load_ready, 1);
    check("t4_post_out", out, 0);
    repeat (3) @(negedge clk);

    // Minimum-size instance: counter boundaries
    lv2 = 1'b1; ld2 = 1'b0;
    check("t5_ready", load_ready2, 1);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lv2 = 1'b0;
      m_o = {m_o[1:0], out2};
      m_v = {m_v[1:0], out_valid2};
      m_d = {m_d[1:0], frame_done2};
    end
    check("t5_out", m_o, 3'b100);
    check("t5_valid", m_v, 3'b110);
    check("t5_done", m_d, 3'b001);
    @(negedge clk);
    check("t5_ready_after", load_ready2, 1);

    // Payload is the value captured at the accepting edge
    wait_idle();
    send(8'h81);
    ld = 8'h7E;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      t6_bits = {t6_bits[6:0], out};
    end
    check("t6_payload", t6_bits, 8'h81);
    wait_idle();

    // Randomised traffic against the model
    repeat (30) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(DW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        lv = 1'b1;
        ld = DW'($urandom);
        @(negedge clk);
        lv = 1'b0;
      end
    end
    wait_idle();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
